// File: rtl/task_prio_scheduler.sv
// -----------------------------------------------------------------------------
// task_prio_scheduler
//
// Ready-list manager and priority scheduler for the RTOS co-processor.
// Each task slot holds valid, priority, run state (ready/suspended/delayed)
// and a wake tick. Commands create/suspend/resume/delay/delete slots. Every
// tick wakes delayed tasks whose wake time has arrived and rotates between
// equal-priority tasks. The highest-priority ready task is published on run_*.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   cmd_valid/ready command handshake (ready only in IDLE with no tick pending)
//   cmd_op          0 create, 1 suspend, 2 resume, 3 delay, 4 delete
//   cmd_id          target slot
//   cmd_prio        priority for create (larger = more important)
//   cmd_delay       delay in ticks for delay (0 = yield)
//   cmd_err         one-cycle pulse while a rejected command sits in EXEC
//   tick_in         tick level, each rising edge is one tick
//   tickval_out     free-running tick counter
//   run_valid/id/prio  selected task
//   switch_out      one-cycle pulse when {run_valid, run_id} changes
// -----------------------------------------------------------------------------
module task_prio_scheduler #(
    parameter int N_TASKS = 16,
    parameter int ID_W    = 4,
    parameter int PRIO_W  = 6,
    parameter int TICK_W  = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [PRIO_W-1:0] cmd_prio,
    input  logic [TICK_W-1:0] cmd_delay,
    output logic              cmd_err,
    input  logic              tick_in,
    output logic [TICK_W-1:0] tickval_out,
    output logic              run_valid,
    output logic [ID_W-1:0]   run_id,
    output logic [PRIO_W-1:0] run_prio,
    output logic              switch_out
);

    // Storage covers every encodable id; slots >= N_TASKS can never be created.
    localparam int              SLOTS   = 1 << ID_W;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_TASKS - 1);
    localparam logic [ID_W:0]   N_EXT   = (ID_W + 1)'(N_TASKS);

    localparam logic [2:0] OP_CREATE  = 3'd0;
    localparam logic [2:0] OP_SUSPEND = 3'd1;
    localparam logic [2:0] OP_RESUME  = 3'd2;
    localparam logic [2:0] OP_DELAY   = 3'd3;
    localparam logic [2:0] OP_DELETE  = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WAKE, S_SCAN, S_COMMIT} state_e;
    typedef enum logic [1:0] {T_READY, T_SUSP, T_DELAY} tstate_e;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_W'(1);
    endfunction

    // FSM / control state
    state_e              state_q;
    logic [ID_W-1:0]     cnt_q;
    logic [ID_W-1:0]     pos_q;
    logic                slot_vld_q [SLOTS];
    tstate_e             slot_st_q  [SLOTS];
    logic                tick_q;
    logic                tick_pend_q, tick_pend_d;
    logic [TICK_W-1:0]   tickval_q, tickval_d;
    logic                err_q;
    logic                cand_vld_q;
    logic                run_valid_q;
    logic [ID_W-1:0]     run_id_q;
    logic [PRIO_W-1:0]   run_prio_q;
    logic                switch_q;

    // Data state (no reset needed: only read once qualified by control state)
    logic [PRIO_W-1:0]   slot_prio_q [SLOTS];
    logic [TICK_W-1:0]   slot_wake_q [SLOTS];
    logic [2:0]          op_q;
    logic [ID_W-1:0]     id_q;
    logic [PRIO_W-1:0]   prio_q;
    logic [TICK_W-1:0]   delay_q;
    logic [ID_W-1:0]     cand_id_q;
    logic [PRIO_W-1:0]   cand_prio_q;

    logic                tick_edge;
    logic                tick_svc;
    logic                cmd_acc;
    logic                err_calc;
    logic                wake_due;
    logic [TICK_W-1:0]   wake_diff;
    logic                vis_ok;
    logic                yield;

    assign tick_edge = tick_in & ~tick_q;
    assign tick_svc  = (state_q == S_IDLE) & tick_pend_q;
    assign cmd_ready = (state_q == S_IDLE) & ~tick_pend_q;
    assign cmd_acc   = cmd_valid & cmd_ready;

    assign tickval_d = tick_edge ? tickval_q + TICK_W'(1) : tickval_q;
    // Edges arriving while a tick is already pending only advance the counter.
    assign tick_pend_d = tick_pend_q ? ~tick_svc : tick_edge;

    // Wrap-safe "wake time reached": sign bit of (now - wake) is clear.
    assign wake_diff = tickval_q - slot_wake_q[cnt_q];
    assign wake_due  = ~wake_diff[TICK_W-1];

    // Strictly greater replaces, so the first visited slot wins a tie.
    assign vis_ok = slot_vld_q[pos_q] && (slot_st_q[pos_q] == T_READY) &&
                    (!cand_vld_q || (slot_prio_q[pos_q] > cand_prio_q));

    assign yield = (op_q == OP_DELAY) && (delay_q == '0) && !err_q;

    always_comb begin
        err_calc = 1'b1;
        case (cmd_op)
            OP_CREATE: err_calc = ({1'b0, cmd_id} >= N_EXT) || slot_vld_q[cmd_id];
            OP_SUSPEND, OP_RESUME, OP_DELAY, OP_DELETE:
                err_calc = ({1'b0, cmd_id} >= N_EXT) || !slot_vld_q[cmd_id];
            default:   err_calc = 1'b1;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pos_q       <= '0;
            tick_q      <= 1'b0;
            tick_pend_q <= 1'b0;
            tickval_q   <= '0;
            err_q       <= 1'b0;
            cand_vld_q  <= 1'b0;
            run_valid_q <= 1'b0;
            run_id_q    <= '0;
            run_prio_q  <= '0;
            switch_q    <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_vld_q[i] <= 1'b0;
                slot_st_q[i]  <= T_READY;
            end
        end else begin
            tick_q      <= tick_in;
            tickval_q   <= tickval_d;
            tick_pend_q <= tick_pend_d;
            err_q       <= 1'b0;
            switch_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick_pend_q) begin
                        // Tick scan starts after the running task so ties rotate.
                        state_q <= S_WAKE;
                        cnt_q   <= '0;
                        pos_q   <= next_id(run_id_q);
                    end else if (cmd_acc) begin
                        state_q <= S_EXEC;
                        err_q   <= err_calc;
                    end
                end
                S_EXEC: begin
                    if (!err_q) begin
                        case (op_q)
                            OP_CREATE: begin
                                slot_vld_q[id_q] <= 1'b1;
                                slot_st_q[id_q]  <= T_READY;
                            end
                            OP_SUSPEND: slot_st_q[id_q] <= T_SUSP;
                            OP_RESUME: begin
                                if (slot_st_q[id_q] == T_SUSP)
                                    slot_st_q[id_q] <= T_READY;
                            end
                            OP_DELAY: begin
                                if (delay_q != '0)
                                    slot_st_q[id_q] <= T_DELAY;
                            end
                            OP_DELETE: slot_vld_q[id_q] <= 1'b0;
                            default: ;
                        endcase
                    end
                    // Commands keep the running task on ties; a yield hands over.
                    pos_q      <= yield ? next_id(run_id_q) : run_id_q;
                    cnt_q      <= '0;
                    cand_vld_q <= 1'b0;
                    state_q    <= S_SCAN;
                end
                S_WAKE: begin
                    if (slot_vld_q[cnt_q] && (slot_st_q[cnt_q] == T_DELAY) && wake_due)
                        slot_st_q[cnt_q] <= T_READY;
                    if (cnt_q == LAST_ID) begin
                        cnt_q      <= '0;
                        cand_vld_q <= 1'b0;
                        state_q    <= S_SCAN;
                    end else begin
                        cnt_q <= cnt_q + ID_W'(1);
                    end
                end
                S_SCAN: begin
                    if (vis_ok)
                        cand_vld_q <= 1'b1;
                    pos_q <= next_id(pos_q);
                    if (cnt_q == LAST_ID) begin
                        cnt_q   <= '0;
                        state_q <= S_COMMIT;
                    end else begin
                        cnt_q <= cnt_q + ID_W'(1);
                    end
                end
                S_COMMIT: begin
                    if (cand_vld_q) begin
                        run_valid_q <= 1'b1;
                        run_id_q    <= cand_id_q;
                        run_prio_q  <= cand_prio_q;
                        switch_q    <= !run_valid_q || (cand_id_q != run_id_q);
                    end else begin
                        // No ready task: id/prio keep their last values.
                        run_valid_q <= 1'b0;
                        switch_q    <= run_valid_q;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (cmd_acc) begin
            op_q    <= cmd_op;
            id_q    <= cmd_id;
            prio_q  <= cmd_prio;
            delay_q <= cmd_delay;
        end
        if ((state_q == S_EXEC) && !err_q) begin
            if (op_q == OP_CREATE)
                slot_prio_q[id_q] <= prio_q;
            if (op_q == OP_DELAY)
                slot_wake_q[id_q] <= tickval_q + delay_q;
        end
        if ((state_q == S_SCAN) && vis_ok) begin
            cand_id_q   <= pos_q;
            cand_prio_q <= slot_prio_q[pos_q];
        end
    end

    assign cmd_err     = err_q;
    assign tickval_out = tickval_q;
    assign run_valid   = run_valid_q;
    assign run_id      = run_id_q;
    assign run_prio    = run_prio_q;
    assign switch_out  = switch_q;

endmodule

// File: tb/tb_task_prio_scheduler.sv
module tb_task_prio_scheduler;

    localparam int N      = 4;
    localparam int ID_W   = 4;
    localparam int PRIO_W = 6;
    localparam int TICK_W = 8;

    localparam logic [2:0] CR = 3'd0, SU = 3'd1, RE = 3'd2, DL = 3'd3, DE = 3'd4;

    logic              aclk, aresetn;
    logic              cmd_valid, cmd_ready, cmd_err;
    logic [2:0]        cmd_op;
    logic [ID_W-1:0]   cmd_id;
    logic [PRIO_W-1:0] cmd_prio;
    logic [TICK_W-1:0] cmd_delay;
    logic              tick_in;
    logic [TICK_W-1:0] tickval_out;
    logic              run_valid;
    logic [ID_W-1:0]   run_id;
    logic [PRIO_W-1:0] run_prio;
    logic              switch_out;

    task_prio_scheduler #(
        .N_TASKS(N), .ID_W(ID_W), .PRIO_W(PRIO_W), .TICK_W(TICK_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_id(cmd_id), .cmd_prio(cmd_prio), .cmd_delay(cmd_delay),
        .cmd_err(cmd_err), .tick_in(tick_in), .tickval_out(tickval_out),
        .run_valid(run_valid), .run_id(run_id), .run_prio(run_prio),
        .switch_out(switch_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        bit          is_tick;
        logic [2:0]  op;
        logic [3:0]  id;
        logic [5:0]  prio;
        logic [7:0]  dly;
        bit          e_err;
        bit          e_vld;
        logic [3:0]  e_id;
        logic [5:0]  e_prio;
        bit          e_sw;
        logic [7:0]  e_tv;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk_cmd(input logic [2:0] op, input logic [3:0] id,
                                    input logic [5:0] pr, input logic [7:0] dl,
                                    input bit er, input bit vl, input logic [3:0] eid,
                                    input logic [5:0] ep, input bit sw, input logic [7:0] tv);
        vec_t v;
        v.is_tick = 1'b0; v.op = op; v.id = id; v.prio = pr; v.dly = dl;
        v.e_err = er; v.e_vld = vl; v.e_id = eid; v.e_prio = ep; v.e_sw = sw; v.e_tv = tv;
        return v;
    endfunction

    function automatic vec_t mk_tick(input bit vl, input logic [3:0] eid,
                                     input logic [5:0] ep, input bit sw, input logic [7:0] tv);
        vec_t v;
        v = mk_cmd(3'd0, 4'd0, 6'd0, 8'd0, 1'b0, vl, eid, ep, sw, tv);
        v.is_tick = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 100 && !cmd_ready; i++) begin
            @(posedge aclk); #1;
        end
        if (!cmd_ready) chk({tag, ".ready_timeout"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        wait_ready(tag);
        sb.push_back(v);
        if (v.is_tick) begin
            tick_in = 1'b1;
            @(posedge aclk); #1;
            tick_in = 1'b0;
            repeat (2*N + 2) @(posedge aclk);
            #1;
        end else begin
            cmd_valid = 1'b1; cmd_op = v.op; cmd_id = v.id;
            cmd_prio = v.prio; cmd_delay = v.dly;
            @(posedge aclk); #1;
            cmd_valid = 1'b0;
            chk({tag, ".err"}, 32'(cmd_err), 32'(sb[0].e_err));
            repeat (N + 2) @(posedge aclk);
            #1;
        end
        e = sb.pop_front();
        chk({tag, ".run_valid"}, 32'(run_valid), 32'(e.e_vld));
        chk({tag, ".run_id"}, 32'(run_id), 32'(e.e_id));
        chk({tag, ".run_prio"}, 32'(run_prio), 32'(e.e_prio));
        chk({tag, ".switch"}, 32'(switch_out), 32'(e.e_sw));
        chk({tag, ".tickval"}, 32'(tickval_out), 32'(e.e_tv));
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy;
        // ---- table: creates, tick rotation, delay/wake, suspend/resume, errors, delete, yield
        vecs.push_back(mk_cmd(CR, 0, 6'h02, 0, 0, 1, 0, 6'h02, 1, 8'd0));
        vecs.push_back(mk_cmd(CR, 1, 6'h2A, 0, 0, 1, 1, 6'h2A, 1, 8'd0));
        vecs.push_back(mk_cmd(CR, 2, 6'h2A, 0, 0, 1, 1, 6'h2A, 0, 8'd0));
        for (int t = 1; t <= 10; t++)
            vecs.push_back(mk_tick(1, (t % 2 == 1) ? 4'd2 : 4'd1, 6'h2A, 1, 8'(t)));
        vecs.push_back(mk_cmd(DL, 1, 0, 8'd3, 0, 1, 2, 6'h2A, 1, 8'd10));
        vecs.push_back(mk_tick(1, 2, 6'h2A, 0, 8'd11));
        vecs.push_back(mk_tick(1, 2, 6'h2A, 0, 8'd12));
        vecs.push_back(mk_tick(1, 1, 6'h2A, 1, 8'd13));
        vecs.push_back(mk_tick(1, 2, 6'h2A, 1, 8'd14));
        vecs.push_back(mk_cmd(SU, 1, 0, 0, 0, 1, 2, 6'h2A, 0, 8'd14));
        vecs.push_back(mk_cmd(SU, 2, 0, 0, 0, 1, 0, 6'h02, 1, 8'd14));
        vecs.push_back(mk_cmd(SU, 0, 0, 0, 0, 0, 0, 6'h02, 1, 8'd14));
        vecs.push_back(mk_cmd(RE, 0, 0, 0, 0, 1, 0, 6'h02, 1, 8'd14));
        vecs.push_back(mk_cmd(CR, 0, 6'h05, 0, 1, 1, 0, 6'h02, 0, 8'd14));
        vecs.push_back(mk_cmd(CR, 4, 6'h01, 0, 1, 1, 0, 6'h02, 0, 8'd14));
        vecs.push_back(mk_cmd(3'd6, 0, 0, 0, 1, 1, 0, 6'h02, 0, 8'd14));
        vecs.push_back(mk_cmd(RE, 1, 0, 0, 0, 1, 1, 6'h2A, 1, 8'd14));
        vecs.push_back(mk_cmd(DE, 1, 0, 0, 0, 1, 0, 6'h02, 1, 8'd14));
        vecs.push_back(mk_cmd(DE, 1, 0, 0, 1, 1, 0, 6'h02, 0, 8'd14));
        vecs.push_back(mk_cmd(SU, 3, 0, 0, 1, 1, 0, 6'h02, 0, 8'd14));
        vecs.push_back(mk_cmd(CR, 1, 6'h03, 0, 0, 1, 1, 6'h03, 1, 8'd14));
        vecs.push_back(mk_cmd(RE, 2, 0, 0, 0, 1, 2, 6'h2A, 1, 8'd14));
        vecs.push_back(mk_cmd(RE, 0, 0, 0, 0, 1, 2, 6'h2A, 0, 8'd14));
        vecs.push_back(mk_cmd(CR, 3, 6'h2A, 0, 0, 1, 2, 6'h2A, 0, 8'd14));
        vecs.push_back(mk_cmd(DL, 2, 0, 8'd0, 0, 1, 3, 6'h2A, 1, 8'd14));
        vecs.push_back(mk_cmd(DE, 3, 0, 0, 0, 1, 2, 6'h2A, 1, 8'd14));

        cmd_valid = 0; cmd_op = 0; cmd_id = 0; cmd_prio = 0; cmd_delay = 0;
        tick_in = 0; aresetn = 0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset.run_valid", 32'(run_valid), 32'd0);
        chk("reset.run_id", 32'(run_id), 32'd0);
        chk("reset.tickval", 32'(tickval_out), 32'd0);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.cmd_err", 32'(cmd_err), 32'd0);
        @(negedge aclk) aresetn = 1;
        @(posedge aclk); #1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // ---- wrap: advance tickval to 0xFE with back-to-back tick pulses
        for (int i = 0; i < 240; i++) begin
            tick_in = 1; @(posedge aclk); #1;
            tick_in = 0; @(posedge aclk); #1;
        end
        wait_ready("wrap.settle");
        chk("wrap.tickval_fe", 32'(tickval_out), 32'hFE);
        chk("wrap.run_id", 32'(run_id), 32'd2);
        apply(mk_cmd(DL, 2, 0, 8'd4, 0, 1, 1, 6'h03, 1, 8'hFE), "wrap.delay");
        apply(mk_tick(1, 1, 6'h03, 0, 8'hFF), "wrap.tFF");
        apply(mk_tick(1, 1, 6'h03, 0, 8'h00), "wrap.t00");
        apply(mk_tick(1, 1, 6'h03, 0, 8'h01), "wrap.t01");
        apply(mk_tick(1, 2, 6'h2A, 1, 8'h02), "wrap.t02");

        // ---- two tick edges during a busy command scan -> one WAKE pass
        wait_ready("busy");
        cmd_valid = 1; cmd_op = RE; cmd_id = 0; cmd_prio = 0; cmd_delay = 0;
        @(posedge aclk); #1;                 // T: accepted
        cmd_valid = 0;
        @(posedge aclk); #1;                 // T+1: SCAN begins
        tick_in = 1; @(posedge aclk); #1;    // T+2: edge 1
        tick_in = 0; @(posedge aclk); #1;
        tick_in = 1; @(posedge aclk); #1;    // T+4: edge 2
        tick_in = 0;
        repeat (N - 2) @(posedge aclk);
        #1;                                  // T+N+2: command committed
        chk("busy.run_id", 32'(run_id), 32'd2);
        chk("busy.switch", 32'(switch_out), 32'd0);
        chk("busy.tickval", 32'(tickval_out), 32'h04);
        chk("busy.ready_pend", 32'(cmd_ready), 32'd0);
        repeat (2*N + 1) @(posedge aclk);
        #1;
        chk("busy.ready_before", 32'(cmd_ready), 32'd0);
        @(posedge aclk); #1;
        chk("busy.ready_after", 32'(cmd_ready), 32'd1);
        nbusy = 0;
        for (int i = 0; i < 3*N; i++) begin
            @(posedge aclk); #1;
            if (!cmd_ready) nbusy++;
        end
        chk("busy.single_pass", 32'(nbusy), 32'd0);
        chk("busy.run_id_after", 32'(run_id), 32'd2);

        // ---- asynchronous reset in the middle of a scan
        cmd_valid = 1; cmd_op = CR; cmd_id = 3; cmd_prio = 6'h01; cmd_delay = 0;
        @(posedge aclk); #1;
        cmd_valid = 0;
        @(posedge aclk); #1;
        @(posedge aclk); #2;
        aresetn = 0;
        #1;
        chk("areset.run_valid", 32'(run_valid), 32'd0);
        chk("areset.run_id", 32'(run_id), 32'd0);
        chk("areset.run_prio", 32'(run_prio), 32'd0);
        chk("areset.tickval", 32'(tickval_out), 32'd0);
        chk("areset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("areset.switch", 32'(switch_out), 32'd0);
        @(negedge aclk) aresetn = 1;
        @(posedge aclk); #1;
        apply(mk_cmd(RE, 0, 0, 0, 1, 0, 0, 6'h00, 0, 8'd0), "areset.empty0");
        apply(mk_cmd(CR, 3, 6'h01, 0, 0, 1, 3, 6'h01, 1, 8'd0), "areset.create3");
        apply(mk_cmd(CR, 0, 6'h02, 0, 0, 1, 0, 6'h02, 1, 8'd0), "areset.create0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
